spi_master_host: RTL

SPI master that drives the bridge's SPI slave port from the host side. It serialises 16-bit words from a valid/ready push interface onto MOSI and returns each word sampled from MISO. Several words can share one nCS assertion, which forms a frame, so a bench or host-side FPGA can issue complete bridge command packets. It is instantiated in system testbenches and in host-side designs that talk to the MIL-STD-1553 bridge.

---
 rtl/spi_master_host_if.sv | 27 ++
 rtl/spi_master_host.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/spi_master_host_if.sv
// Host-side bus of the SPI master: word push/return handshake plus the four SPI pins.
// The master modport is the view taken by spi_master_host; the slave modport is the host/bench view.
interface spi_master_host_if #(
    parameter int WORD_WIDTH = 16
);
    logic [WORD_WIDTH-1:0] txData;
    logic                  txValid;
    logic                  frameEnd;
    logic                  txReady;
    logic [WORD_WIDTH-1:0] rxData;
    logic                  rxValid;
    logic                  busy;
    logic                  nCS;
    logic                  sck;
    logic                  mosi;
    logic                  miso;

    modport master (
        input  txData, txValid, frameEnd, miso,
        output txReady, rxData, rxValid, busy, nCS, sck, mosi
    );

    modport slave (
        output txData, txValid, frameEnd, miso,
        input  txReady, rxData, rxValid, busy, nCS, sck, mosi
    );
endinterface

// File: rtl/spi_master_host.sv
// Mode-0 SPI master: pushes 16-bit words out MSB first, returns the word sampled from MISO,
// and keeps nCS low across consecutive words until a word tagged frameEnd completes.
module spi_master_host #(
    parameter int DIV        = 4,
    parameter int WORD_WIDTH = 16
) (
    input  logic               clk,
    input  logic               nRst,
    spi_master_host_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        WAIT,
        HOLD,
        DESELECT
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
    localparam logic [4:0] BIT_LAST = 5'(WORD_WIDTH - 1);

    state_t                r_state;
    logic [7:0]            r_div;
    logic [4:0]            r_bit;
    logic                  r_phase;
    logic                  r_last;
    logic [WORD_WIDTH-1:0] r_tx;
    logic [WORD_WIDTH-1:0] r_rx;
    logic [WORD_WIDTH-1:0] r_rxData;
    logic                  r_rxValid;
    logic                  r_txReady;
    logic                  r_busy;
    logic                  r_nCS;
    logic                  r_sck;
    logic                  r_mosi;

    logic w_accept;
    logic w_div_done;

    assign w_accept   = bus.txValid && r_txReady;
    assign w_div_done = (r_div == DIV_LAST);

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state   <= IDLE;
            r_div     <= 8'd0;
            r_bit     <= 5'd0;
            r_phase   <= 1'b0;
            r_last    <= 1'b0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rxData  <= '0;
            r_rxValid <= 1'b0;
            r_txReady <= 1'b1;
            r_busy    <= 1'b0;
            r_nCS     <= 1'b1;
            r_sck     <= 1'b0;
            r_mosi    <= 1'b0;
        end else begin
            r_rxValid <= 1'b0;
            r_div     <= w_div_done ? 8'd0 : r_div + 8'd1;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_tx      <= bus.txData;
                        r_mosi    <= bus.txData[WORD_WIDTH-1];
                        r_last    <= bus.frameEnd;
                        r_div     <= 8'd0;
                        r_nCS     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_txReady <= 1'b0;
                        r_state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (w_div_done) begin
                        r_phase <= 1'b0;
                        r_bit   <= 5'd0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_div_done) begin
                        if (!r_phase) begin
                            // Rising sck: capture MISO while the slave holds it stable.
                            r_sck   <= 1'b1;
                            r_phase <= 1'b1;
                            r_rx    <= {r_rx[WORD_WIDTH-2:0], bus.miso};
                        end else begin
                            r_sck   <= 1'b0;
                            r_phase <= 1'b0;
                            if (r_bit == BIT_LAST) begin
                                r_rxData  <= r_rx;
                                r_rxValid <= 1'b1;
                                r_txReady <= !r_last;
                                r_state   <= r_last ? HOLD : WAIT;
                            end else begin
                                r_bit  <= r_bit + 5'd1;
                                r_tx   <= {r_tx[WORD_WIDTH-2:0], 1'b0};
                                r_mosi <= r_tx[WORD_WIDTH-2];
                            end
                        end
                    end
                end
                WAIT: begin
                    // nCS stays asserted indefinitely; the next word skips SETUP.
                    if (w_accept) begin
                        r_tx      <= bus.txData;
                        r_mosi    <= bus.txData[WORD_WIDTH-1];
                        r_last    <= bus.frameEnd;
                        r_div     <= 8'd0;
                        r_phase   <= 1'b0;
                        r_bit     <= 5'd0;
                        r_txReady <= 1'b0;
                        r_state   <= SHIFT;
                    end
                end
                HOLD: begin
                    if (w_div_done) begin
                        r_nCS   <= 1'b1;
                        r_phase <= 1'b0;
                        r_state <= DESELECT;
                    end
                end
                DESELECT: begin
                    // Two DIV-long phases give 2*DIV without widening the divider.
                    if (w_div_done) begin
                        r_phase <= !r_phase;
                        if (r_phase) begin
                            r_txReady <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.txReady = r_txReady;
    assign bus.rxData  = r_rxData;
    assign bus.rxValid = r_rxValid;
    assign bus.busy    = r_busy;
    assign bus.nCS     = r_nCS;
    assign bus.sck     = r_sck;
    assign bus.mosi    = r_mosi;
endmodule
